// File: rtl/writeback_if.sv
// Bundles the ALU result port, the load-return port and the register-file write port
// of the writeback unit.
interface writeback_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned LQ_DEPTH = 4
);
    logic                        alu_valid;
    logic [REG_AW-1:0]           alu_dest;
    logic [DATA_W-1:0]           alu_data;
    logic                        ld_valid;
    logic                        ld_ready;
    logic [REG_AW-1:0]           ld_dest;
    logic [DATA_W-1:0]           ld_data;
    logic                        regWrite;
    logic [REG_AW-1:0]           regWriteNum;
    logic [DATA_W-1:0]           writeData;
    logic [(1 << REG_AW)-1:0]    pending_mask;
    logic [$clog2(LQ_DEPTH):0]   lq_count;

    modport master (
        output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
        input  ld_ready, regWrite, regWriteNum, writeData, pending_mask, lq_count
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
        output ld_ready, regWrite, regWriteNum, writeData, pending_mask, lq_count
    );
endinterface

// File: rtl/writeback_unit.sv
// Merges single-cycle ALU results and in-order buffered load returns onto one registered
// register-file write port, squashing queued loads overtaken by a younger ALU write.
module writeback_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned LQ_DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    writeback_if.slave wb
);
    localparam int unsigned PTR_W    = $clog2(LQ_DEPTH);
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    logic [REG_AW-1:0]   lqDestQ [LQ_DEPTH];
    logic [DATA_W-1:0]   lqDataQ [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] lqLiveQ, lqLiveD;
    logic [PTR_W-1:0]    headQ, headD, tailQ, tailD;
    logic [PTR_W:0]      countQ, countD;
    logic [NUM_REGS-1:0] maskQ, maskD;

    logic                wrEnQ, wrEnD;
    logic [REG_AW-1:0]   wrNumQ, wrNumD;
    logic [DATA_W-1:0]   wrDataQ, wrDataD;

    logic full, push, pop, aluWr;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign full  = (countQ == (PTR_W + 1)'(LQ_DEPTH));
    assign aluWr = wb.alu_valid && (wb.alu_dest != '0);
    assign push  = wb.ld_valid && !full && (wb.ld_dest != '0);
    assign pop   = !aluWr && (countQ != '0);

    always_comb begin
        lqLiveD = lqLiveQ;
        headD   = headQ;
        tailD   = tailQ;
        countD  = countQ;
        wrEnD   = 1'b0;
        wrNumD  = wrNumQ;
        wrDataD = wrDataQ;
        maskD   = '0;

        // Kill runs before the push so a load accepted this cycle counts as younger.
        if (aluWr) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (lqDestQ[i] == wb.alu_dest) lqLiveD[i] = 1'b0;
            end
        end

        if (aluWr) begin
            wrEnD   = 1'b1;
            wrNumD  = wb.alu_dest;
            wrDataD = wb.alu_data;
        end else if (pop && lqLiveQ[headQ]) begin
            wrEnD   = 1'b1;
            wrNumD  = lqDestQ[headQ];
            wrDataD = lqDataQ[headQ];
        end

        if (pop) begin
            lqLiveD[headQ] = 1'b0;
            headD          = headQ + PTR_W'(1);
        end
        if (push) begin
            lqLiveD[tailQ] = 1'b1;
            tailD          = tailQ + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   countD = countQ + (PTR_W + 1)'(1);
            2'b01:   countD = countQ - (PTR_W + 1)'(1);
            default: countD = countQ;
        endcase

        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lqLiveD[i]) begin
                if (push && (tailQ == PTR_W'(i))) maskD[wb.ld_dest] = 1'b1;
                else                              maskD[lqDestQ[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lqLiveQ <= '0;
            headQ   <= '0;
            tailQ   <= '0;
            countQ  <= '0;
            maskQ   <= '0;
            wrEnQ   <= 1'b0;
            wrNumQ  <= '0;
            wrDataQ <= '0;
        end else begin
            lqLiveQ <= lqLiveD;
            headQ   <= headD;
            tailQ   <= tailD;
            countQ  <= countD;
            maskQ   <= maskD;
            wrEnQ   <= wrEnD;
            wrNumQ  <= wrNumD;
            wrDataQ <= wrDataD;
        end
    end

    // Payload storage needs no reset: the live bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            lqDestQ[tailQ] <= wb.ld_dest;
            lqDataQ[tailQ] <= wb.ld_data;
        end
    end

    assign wb.ld_ready     = !full;
    assign wb.regWrite     = wrEnQ;
    assign wb.regWriteNum  = wrNumQ;
    assign wb.writeData    = wrDataQ;
    assign wb.pending_mask = maskQ;
    assign wb.lq_count     = countQ;
endmodule
